clk_ratio_monitor: RTL
======================

Name: clk_ratio_monitor

Overview:
- Receive-side checker for divided clocks produced elsewhere in the design.
- Samples a slow divided-clock input, measures its period in cycles of the fast clock `clk`, and compares the result against a programmed expected period.
- Declares lock after a run of consecutive matches. Flags a fault on mismatch or on a missing edge.
- Sits beside every divider instance as a self-check. Outputs feed status registers and interrupt logic.

Parameters:
- CNT_W, 8, width of the period counter and of the period ports.
- LOCK_COUNT, 4, number of consecutive matching periods needed to assert `locked`.
- TOL, 1, allowed absolute difference, in `clk` cycles, between measured and expected period.

Ports:
- clk  input  1  fast reference clock; all logic is on posedge clk.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = monitor runs; 0 = forces the IDLE state.
- div_in  input  1  divided clock under test; treated as asynchronous to clk.
- exp_period  input  CNT_W  expected period in clk cycles; sampled on every edge event.
- period  output  CNT_W  last measured period.
- period_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  the input matches the expected period.
- fault  output  1  sticky mismatch or timeout indication.
- timeout  output  1  sticky flag: the period counter saturated with no edge.

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is asynchronous and active-low.
- Reset values: all registers 0, so period=0, period_valid=0, locked=0, fault=0, timeout=0. State is IDLE.
- Synchronizer and edge detect:
  - div_in passes through a 2-flop synchronizer, then one history register.
  - `rise` = sync & ~hist.
  - `rise` occurs 3 clk edges after div_in goes high.
- Cycle counter `cnt`:
  - Reloads to 1 on the cycle `rise` is seen; otherwise increments.
  - Saturates at all-ones; it never wraps.
- Measurement on `rise` while in MEASURE or LOCKED:
  - period <= cnt, and period_valid pulses for one cycle.
  - The period register holds its value between measurements.
- Match rule: |cnt - exp_period| <= TOL, computed at CNT_W+1 bits so there is no underflow.
- FSM states: IDLE, ARM, MEASURE, LOCKED, FAULT.
  - IDLE: cnt=0, match counter=0, locked=0, fault=0, timeout=0. Goes to ARM when enable=1.
  - ARM: waits for the first `rise`. That edge only reloads cnt, with no measurement. Goes to MEASURE.
  - MEASURE: on `rise` with a match, the match counter increments. When it reaches LOCK_COUNT, go to LOCKED. On `rise` with a mismatch, the match counter clears and the state stays in MEASURE (acquisition tolerates bad periods).
  - LOCKED: locked=1. On `rise` with a mismatch, go to FAULT.
  - FAULT: fault=1, locked=0. Sticky until enable=0 or reset.
- Timeout: cnt reaching all-ones in ARM, MEASURE or LOCKED sets timeout=1 and moves to FAULT.
- locked rises on the same clk edge that the LOCK_COUNT-th matching period_valid pulse is registered.
- enable=0 in any state: IDLE on the next clk edge. locked, fault and timeout clear that same edge. Any in-flight measurement is discarded.
- exp_period changing mid-run: takes effect at the next `rise`; there is no re-acquisition unless a mismatch results.
- Simultaneous `rise` and saturation: `rise` wins. The measurement is cnt = all-ones, judged by the match rule.
- Asserting reset mid-operation clears everything asynchronously. After release the block restarts from IDLE.

Optional Feature:
- Macro: CLK_RATIO_MON_STATS_EN.
- Defined: adds outputs `min_period` and `max_period` (CNT_W each).
  - They update on every period_valid.
  - They reset to all-ones and 0 respectively, and return to those values when in IDLE.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package `clk_mon_pkg` holds:
  - the state enum (IDLE, ARM, MEASURE, LOCKED, FAULT) at 3-bit encoding;
  - the default CNT_W, LOCK_COUNT and TOL constants.
- One sub-module: `sync_2ff`, a 1-bit 2-flop synchronizer with async active-low reset. It is reusable elsewhere.
- Edge detect, counter, compare and FSM stay in the top module.

Test Plan:
- Divide-by-4 source (div_in toggles every 2 clk, so period 4), exp_period=4, enable=1 → period_valid pulses every 4 clk with period=4; locked=1 after the 4th matching measurement; fault=0.
- Period-16 source, exp_period=15, TOL=1 → locks. Then exp_period=13 → FAULT on the next edge, with fault=1 and locked=0; fault holds until enable drops.
- Period-8 source for 3 periods, then 1 period of 10, then period 8 → the match counter clears on the bad period; locked first asserts after 4 further good periods.
- Locked on period 8, then div_in held low → cnt saturates at 255 (CNT_W=8) → timeout=1, fault=1, state FAULT.
- enable dropped while locked, then re-raised → outputs clear the next cycle; ARM discards the first edge; relock after 5 edges.
- reset asserted mid-MEASURE asynchronously (no clk edge) → all outputs are 0 immediately. With CLK_RATIO_MON_STATS_EN, min_period=255 and max_period=0; after periods 8, 6, 9 they read 6 and 9.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the divided-clock ratio monitor:
//   - mon_state_e : monitor FSM state encoding (3 bits)
//   - DEF_CNT_W, DEF_LOCK_COUNT, DEF_TOL : default parameter values
// -----------------------------------------------------------------------------
package clk_mon_pkg;

   localparam int unsigned DEF_CNT_W      = 8;  // period counter / port width
   localparam int unsigned DEF_LOCK_COUNT = 4;  // consecutive matches to lock
   localparam int unsigned DEF_TOL        = 1;  // allowed |measured - expected|

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_MEASURE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_FAULT   = 3'd4
   } mon_state_e;

endpackage : clk_mon_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level
// into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   i_d   : asynchronous input level
//   o_q   : synchronized level, two clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // NOTE: sequential state always uses non-blocking assignments so both
   // flops sample their inputs from the same edge instead of collapsing
   // into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor
// Receive-side self-check for a divided clock. Measures the period of div_in
// in clk cycles, compares it against exp_period (+/- TOL), declares lock
// after LOCK_COUNT consecutive matches and flags a sticky fault on a
// mismatch while locked or when no edge arrives before the counter saturates.
//
// Ports:
//   clk          : fast reference clock, all logic on posedge
//   reset        : asynchronous active-low reset
//   enable       : 1 = run, 0 = return to IDLE on the next edge
//   div_in       : divided clock under test (asynchronous to clk)
//   exp_period   : expected period in clk cycles, sampled at each edge event
//   period       : last measured period
//   period_valid : one-cycle pulse when period updates
//   locked       : input matches the expected period
//   fault        : sticky mismatch / timeout indication
//   timeout      : sticky, counter saturated without an edge
//   min_period   : smallest period seen since leaving IDLE (stats build only)
//   max_period   : largest period seen since leaving IDLE (stats build only)
//
// Build option: define CLK_RATIO_MON_STATS_EN to add min_period/max_period.
// -----------------------------------------------------------------------------
module clk_ratio_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int unsigned TOL        = DEF_TOL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_in,
   input  logic [CNT_W-1:0] exp_period,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             fault,
   output logic             timeout
`ifdef CLK_RATIO_MON_STATS_EN
   ,
   output logic [CNT_W-1:0] min_period,
   output logic [CNT_W-1:0] max_period
`endif
);

   localparam int unsigned      MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // ---------------------------------------------------------------------
   // Synchronizer and rising-edge detect
   // ---------------------------------------------------------------------
   logic w_sync;
   logic r_hist;
   logic w_rise;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (reset),
      .i_d   (div_in),
      .o_q   (w_sync)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_hist <= 1'b0;
      else        r_hist <= w_sync;
   end

   assign w_rise = w_sync & ~r_hist;

   // ---------------------------------------------------------------------
   // State, counters and compare
   // ---------------------------------------------------------------------
   mon_state_e         r_state;
   mon_state_e         w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [MATCH_W-1:0] r_match_cnt;
   logic [CNT_W-1:0]   r_period;
   logic               r_period_valid;
   logic               r_timeout;

   logic               w_active;     // ARM, MEASURE or LOCKED
   logic               w_measuring;  // MEASURE or LOCKED
   logic               w_measure;    // this edge records a period
   logic               w_sat;        // saturated with no edge: timeout
   logic [CNT_W:0]     w_cnt_ext;
   logic [CNT_W:0]     w_exp_ext;
   logic [CNT_W:0]     w_abs_diff;
   logic               w_match;
   logic               w_match_last;

   assign w_measuring = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
   assign w_active    = w_measuring || (r_state == ST_ARM);
   assign w_measure   = enable && w_rise && w_measuring;
   // An edge arriving together with saturation is a measurement, not a timeout.
   assign w_sat       = w_active && (r_cnt == CNT_MAX) && !w_rise;

   // One extra bit so the difference cannot underflow.
   assign w_cnt_ext    = {1'b0, r_cnt};
   assign w_exp_ext    = {1'b0, exp_period};
   assign w_abs_diff   = (w_cnt_ext >= w_exp_ext) ? (w_cnt_ext - w_exp_ext)
                                                  : (w_exp_ext - w_cnt_ext);
   assign w_match      = (w_abs_diff <= (CNT_W + 1)'(TOL));
   assign w_match_last = (r_match_cnt == MATCH_W'(LOCK_COUNT - 1));

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM: next-state logic
   // NOTE: the default assignment at the top of a combinational block keeps
   // every path driven, so no latch is inferred for unlisted cases.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_ARM;
            ST_ARM: begin
               if (w_rise)     w_state_nxt = ST_MEASURE;
               else if (w_sat) w_state_nxt = ST_FAULT;
            end
            ST_MEASURE: begin
               if (w_rise) begin
                  if (w_match && w_match_last) w_state_nxt = ST_LOCKED;
               end else if (w_sat) begin
                  w_state_nxt = ST_FAULT;
               end
            end
            ST_LOCKED: begin
               if (w_rise) begin
                  if (!w_match) w_state_nxt = ST_FAULT;
               end else if (w_sat) begin
                  w_state_nxt = ST_FAULT;
               end
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM: outputs decoded from the registered state
   always_comb begin
      locked = (r_state == ST_LOCKED);
      fault  = (r_state == ST_FAULT);
   end

   // Cycle counter: reload to 1 on an edge, saturate at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!enable || r_state == ST_IDLE) begin
         r_cnt <= '0;
      end else if (w_rise) begin
         r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Consecutive-match counter, only meaningful during acquisition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_match_cnt <= '0;
      end else if (!enable || r_state == ST_IDLE) begin
         r_match_cnt <= '0;
      end else if (r_state == ST_MEASURE && w_rise) begin
         r_match_cnt <= w_match ? (r_match_cnt + 1'b1) : '0;
      end
   end

   // Measurement register and valid pulse; period holds between measurements.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period       <= '0;
         r_period_valid <= 1'b0;
      end else begin
         r_period_valid <= w_measure;
         if (w_measure) r_period <= r_cnt;
      end
   end

   // Sticky timeout, cleared only by leaving to IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timeout <= 1'b0;
      end else if (!enable || r_state == ST_IDLE) begin
         r_timeout <= 1'b0;
      end else if (w_sat) begin
         r_timeout <= 1'b1;
      end
   end

   assign period       = r_period;
   assign period_valid = r_period_valid;
   assign timeout      = r_timeout;

`ifdef CLK_RATIO_MON_STATS_EN
   // ---------------------------------------------------------------------
   // Min/max period statistics, updated with every measurement.
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] r_min_period;
   logic [CNT_W-1:0] r_max_period;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_min_period <= CNT_MAX;
         r_max_period <= '0;
      end else if (!enable || r_state == ST_IDLE) begin
         r_min_period <= CNT_MAX;
         r_max_period <= '0;
      end else if (w_measure) begin
         if (r_cnt < r_min_period) r_min_period <= r_cnt;
         if (r_cnt > r_max_period) r_max_period <= r_cnt;
      end
   end

   assign min_period = r_min_period;
   assign max_period = r_max_period;
`endif

endmodule : clk_ratio_monitor
